tm1638_key_events: RTL and testbench

//  Downstream consumer of the TM1638 board controller's raw keys[] bus.
//  - Debounces each key on a 1 ms tick.
//  - Exposes the clean level of every key.
//  - Emits press/release events through a small FIFO with a valid/ready port,
//    so lab logic sees one event per key action instead of polling levels.

---
 rtl/tm1638_key_pkg.sv | 20 ++
 rtl/tm1638_event_fifo.sv | 42 ++++
 rtl/tm1638_key_events.sv | 153 +++++++++++++++
 tb/tb_tm1638_key_events.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tm1638_key_pkg.sv
// tm1638_key_pkg: shared types and helpers for the TM1638 key event block.
//   KEY_IDX_W   : event index width, sized for the largest board (16 keys)
//   key_event_t : one queued event {rpt, press, idx}
//   key_idx_w   : index width for a given key count
//   tick_cycles : clock cycles per 1 ms tick for a given clock in MHz
package tm1638_key_pkg;
  function automatic int key_idx_w(input int w_key);
    return $clog2(w_key);
  endfunction
  function automatic int tick_cycles(input int clk_mhz);
    return clk_mhz * 1000;
  endfunction
  localparam int KEY_IDX_W = key_idx_w(16);
  // "repeat" is a reserved word, so the auto-repeat flag is named rpt
  typedef struct packed {
    logic                 rpt;
    logic                 press;
    logic [KEY_IDX_W-1:0] idx;
  } key_event_t;
endpackage

// File: rtl/tm1638_event_fifo.sv
// tm1638_event_fifo: small event FIFO; a full FIFO accepts push and pop in the same cycle.
//   clk, rst_n  : clock, asynchronous active-low reset
//   push, din   : write request and data (dropped when full and not popping)
//   pop         : remove head (ignored when empty)
//   dout        : head entry, 0 when empty
//   full, empty : occupancy flags
module tm1638_event_fifo
  import tm1638_key_pkg::*;
#(
  parameter int  depth = 4,
  parameter type evt_t = key_event_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  evt_t din,
  input  logic pop,
  output evt_t dout,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(depth);
  evt_t mem [depth];
  // one extra pointer bit separates full from empty
  logic [AW:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign empty   = wr_ptr == rd_ptr;
  assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
endmodule

// File: rtl/tm1638_key_events.sv
// tm1638_key_events: debounces raw TM1638 keys and queues press/release events.
//   clk, rst_n   : clock, asynchronous active-low reset
//   keys         : raw key levels (clk domain)
//   key_state    : debounced levels, 1 = pressed
//   evt_valid    : event FIFO head valid
//   evt_ready    : consumer accepts the head
//   evt_key      : key index of the head event
//   evt_press    : 1 = press, 0 = release
//   evt_repeat   : 1 = auto-repeat press (always 0 unless TM1638_KEY_AUTOREPEAT_EN)
//   evt_overflow : sticky, a pending event was overwritten before it was queued
// Optional feature: define TM1638_KEY_AUTOREPEAT_EN to enable the auto-repeat timer.
module tm1638_key_events
  import tm1638_key_pkg::*;
#(
  parameter int clk_mhz         = 50,
  parameter int w_key           = 8,
  parameter int debounce_ms     = 10,
  parameter int fifo_depth      = 4,
  parameter int repeat_delay_ms = 500,
  parameter int repeat_rate_ms  = 100
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [w_key-1:0]     keys,
  output logic [w_key-1:0]     key_state,
  output logic                 evt_valid,
  input  logic                 evt_ready,
  output logic [KEY_IDX_W-1:0] evt_key,
  output logic                 evt_press,
  output logic                 evt_repeat,
  output logic                 evt_overflow
);
  localparam int TICKS = tick_cycles(clk_mhz);
  localparam int PW    = $clog2(TICKS);
  localparam int DW    = $clog2(debounce_ms + 1);
  logic [PW-1:0]        pre;
  logic                 tick;
  logic [w_key-1:0]     keys_q, tog, pend, pend_kind, pend_rpt, rep_set;
  logic [DW-1:0]        db_cnt [w_key];
  logic [KEY_IDX_W-1:0] sel;
  logic                 sel_kind, sel_rpt, push, pop, full, empty;
  key_event_t           head;
  assign tick = pre == PW'(TICKS - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pre <= '0;
    else pre <= tick ? '0 : pre + 1'b1;
  always_comb
    for (int i = 0; i < w_key; i++)
      tog[i] = tick && (keys_q[i] != key_state[i]) && (db_cnt[i] == DW'(debounce_ms - 1));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      keys_q    <= '0;
      key_state <= '0;
      for (int i = 0; i < w_key; i++) db_cnt[i] <= '0;
    end else begin
      keys_q    <= keys;
      key_state <= key_state ^ tog;
      for (int i = 0; i < w_key; i++)
        db_cnt[i] <= (keys_q[i] == key_state[i] || tog[i]) ? '0 : tick ? db_cnt[i] + 1'b1 : db_cnt[i];
    end
  // fixed priority: the lowest pending index wins
  always_comb begin
    sel      = '0;
    sel_kind = 1'b0;
    sel_rpt  = 1'b0;
    for (int i = w_key - 1; i >= 0; i--)
      if (pend[i]) begin
        sel      = KEY_IDX_W'(i);
        sel_kind = pend_kind[i];
        sel_rpt  = pend_rpt[i];
      end
  end
  assign pop  = evt_valid && evt_ready;
  assign push = |pend && (!full || pop);
  // a debounce toggle outranks a repeat for the same key in the same cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pend         <= '0;
      pend_kind    <= '0;
      pend_rpt     <= '0;
      evt_overflow <= 1'b0;
    end else begin
      for (int i = 0; i < w_key; i++)
        if (tog[i] || rep_set[i]) begin
          pend[i]      <= 1'b1;
          pend_kind[i] <= tog[i] ? ~key_state[i] : 1'b1;
          pend_rpt[i]  <= !tog[i];
          if (pend[i] && !(push && sel == KEY_IDX_W'(i))) evt_overflow <= 1'b1;
        end else if (push && sel == KEY_IDX_W'(i)) begin
          pend[i] <= 1'b0;
        end
    end
  tm1638_event_fifo #(.depth(fifo_depth), .evt_t(key_event_t)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   ('{rpt: sel_rpt, press: sel_kind, idx: sel}),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );
  assign evt_valid  = !empty;
  assign evt_key    = head.idx;
  assign evt_press  = head.press;
  assign evt_repeat = head.rpt;
`ifdef TM1638_KEY_AUTOREPEAT_EN
  localparam int RMAX = (repeat_delay_ms > repeat_rate_ms) ? repeat_delay_ms : repeat_rate_ms;
  localparam int RW   = $clog2(RMAX + 1);
  logic                 rep_on, rep_held, rep_rel, press_any, rep_fire;
  logic [KEY_IDX_W-1:0] rep_key, press_idx;
  logic [RW-1:0]        rep_cnt;
  always_comb begin
    press_any = 1'b0;
    press_idx = '0;
    rep_held  = 1'b0;
    rep_rel   = 1'b0;
    for (int i = w_key - 1; i >= 0; i--) begin
      if (tog[i] && !key_state[i]) begin
        press_any = 1'b1;
        press_idx = KEY_IDX_W'(i);
      end
      if (rep_key == KEY_IDX_W'(i)) begin
        rep_held = key_state[i];
        rep_rel  = tog[i] && key_state[i];
      end
    end
    rep_fire = rep_on && tick && rep_cnt == RW'(1) && rep_held;
    for (int i = 0; i < w_key; i++) rep_set[i] = rep_fire && rep_key == KEY_IDX_W'(i);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rep_on  <= 1'b0;
      rep_key <= '0;
      rep_cnt <= '0;
    end else if (press_any) begin
      rep_on  <= 1'b1;
      rep_key <= press_idx;
      rep_cnt <= RW'(repeat_delay_ms);
    end else if (rep_rel) begin
      rep_on <= 1'b0;
    end else if (rep_on && tick) begin
      if (rep_cnt == RW'(1)) begin
        rep_cnt <= RW'(repeat_rate_ms);
        rep_on  <= rep_held;
      end else begin
        rep_cnt <= rep_cnt - 1'b1;
      end
    end
`else
  assign rep_set = '0;
`endif
endmodule

// File: tb/tb_tm1638_key_events.sv
// tb_tm1638_key_events: directed self-checking bench for tm1638_key_events (1 MHz, 2 ms debounce).
module tb_tm1638_key_events;
  import tm1638_key_pkg::*;
  logic                 clk = 1'b0, rst_n = 1'b1, evt_ready = 1'b0;
  logic [7:0]           keys = 8'h00, key_state;
  logic                 evt_valid, evt_press, evt_repeat, evt_overflow;
  logic [KEY_IDX_W-1:0] evt_key;
  int                   total = 0, bad = 0, cyc = 0;

  tm1638_key_events #(
    .clk_mhz(1), .w_key(8), .debounce_ms(2), .fifo_depth(4),
    .repeat_delay_ms(3), .repeat_rate_ms(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .keys(keys), .key_state(key_state),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_key(evt_key),
    .evt_press(evt_press), .evt_repeat(evt_repeat), .evt_overflow(evt_overflow)
  );

  always #5 clk = ~clk;
  // cycles since reset release; key_state may only change at edges where cyc is a multiple of 1000
  always @(posedge clk) cyc <= rst_n ? cyc + 1 : 0;

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input logic [7:0] k);
    rst_n = 1'b0;
    keys = k;
    evt_ready = 1'b0;
    step(3);
    rst_n = 1'b1;
  endtask

  task automatic wait_ks(input logic [7:0] exp, input int bound, output logic ok, output int at);
    ok = 1'b0;
    at = -1;
    for (int n = 0; n < bound && !ok; n++) begin
      step();
      if (key_state === exp) begin
        ok = 1'b1;
        at = cyc;
      end
    end
  endtask

  task automatic pop_one(output logic v, output logic [KEY_IDX_W-1:0] k, output logic p, output logic r);
    v = evt_valid;
    k = evt_key;
    p = evt_press;
    r = evt_repeat;
    evt_ready = 1'b1;
    step();
    evt_ready = 1'b0;
  endtask

  task automatic test_reset;
    do_reset(8'h00);
    step(2);
    total++;
    if (key_state !== 8'h00) begin bad++; $display("FAIL reset_key_state: got %h want 00", key_state); end
    total++;
    if (evt_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", evt_valid); end
    total++;
    if (evt_overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow: got %b want 0", evt_overflow); end
    total++;
    if ({evt_key, evt_press, evt_repeat} !== '0) begin
      bad++; $display("FAIL reset_head: got key=%0d p=%b r=%b want 0", evt_key, evt_press, evt_repeat);
    end
  endtask

  task automatic test_bounce;
    logic ok, early;
    int at, s, r;
    do_reset(8'h00);
    early = 1'b0;
    for (int n = 0; n < 10; n++) begin
      keys[3] = ~keys[3];
      for (int c = 0; c < 300; c++) begin
        step();
        if (evt_valid !== 1'b0 || key_state !== 8'h00) early = 1'b1;
      end
    end
    total++;
    if (early) begin bad++; $display("FAIL bounce_quiet: got activity while bouncing want none"); end
    keys[3] = 1'b1;
    s = cyc;
    r = ((s + 2 + 999) / 1000) * 1000 + 1000;
    wait_ks(8'h08, 3000, ok, at);
    total++;
    if (!ok || at != r) begin bad++; $display("FAIL bounce_rise: got cycle %0d want %0d", at, r); end
    total++;
    if (evt_valid !== 1'b0) begin bad++; $display("FAIL bounce_latency0: got valid=%b want 0", evt_valid); end
    step();
    total++;
    if ({evt_valid, evt_key, evt_press, evt_repeat} !== {1'b1, 4'd3, 1'b1, 1'b0}) begin
      bad++; $display("FAIL bounce_event: got v=%b key=%0d p=%b r=%b want v=1 key=3 p=1 r=0",
                      evt_valid, evt_key, evt_press, evt_repeat);
    end
    step(3);
    total++;
    if ({evt_valid, evt_key, evt_press} !== {1'b1, 4'd3, 1'b1}) begin
      bad++; $display("FAIL bounce_hold: got v=%b key=%0d p=%b want v=1 key=3 p=1", evt_valid, evt_key, evt_press);
    end
    evt_ready = 1'b1;
    step();
    evt_ready = 1'b0;
    total++;
    if (evt_valid !== 1'b0) begin bad++; $display("FAIL bounce_pop: got valid=%b want 0", evt_valid); end
  endtask

  task automatic test_simultaneous;
    logic ok;
    int at;
    do_reset(8'h00);
    keys = 8'h81;
    wait_ks(8'h81, 3000, ok, at);
    total++;
    if (!ok || at != 2000) begin bad++; $display("FAIL simul_rise: got cycle %0d want 2000", at); end
    evt_ready = 1'b1;
    step();
    total++;
    if ({evt_valid, evt_key, evt_press} !== {1'b1, 4'd0, 1'b1}) begin
      bad++; $display("FAIL simul_first: got v=%b key=%0d p=%b want v=1 key=0 p=1", evt_valid, evt_key, evt_press);
    end
    step();
    total++;
    if ({evt_valid, evt_key, evt_press} !== {1'b1, 4'd7, 1'b1}) begin
      bad++; $display("FAIL simul_second: got v=%b key=%0d p=%b want v=1 key=7 p=1", evt_valid, evt_key, evt_press);
    end
    step();
    total++;
    if (evt_valid !== 1'b0) begin bad++; $display("FAIL simul_drained: got valid=%b want 0", evt_valid); end
    step(3);
    total++;
    if ({evt_valid, evt_overflow} !== 2'b00) begin
      bad++; $display("FAIL empty_ready: got v=%b ovf=%b want 0 0", evt_valid, evt_overflow);
    end
    evt_ready = 1'b0;
  endtask

  task automatic test_full;
    logic ok, v, p, r;
    logic [KEY_IDX_W-1:0] k;
    int at;
    logic [KEY_IDX_W-1:0] ek [5] = '{4'd0, 4'd1, 4'd2, 4'd0, 4'd1};
    logic                 ep [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    do_reset(8'h00);
    keys = 8'h07;
    wait_ks(8'h07, 3000, ok, at);
    keys = 8'h04;
    wait_ks(8'h04, 3000, ok, at);
    step(5);
    total++;
    if ({evt_valid, evt_key, evt_press, evt_overflow} !== {1'b1, 4'd0, 1'b1, 1'b0}) begin
      bad++; $display("FAIL full_head: got v=%b key=%0d p=%b ovf=%b want v=1 key=0 p=1 ovf=0",
                      evt_valid, evt_key, evt_press, evt_overflow);
    end
    keys = 8'h06;
    wait_ks(8'h06, 3000, ok, at);
    step(2);
    total++;
    if (evt_overflow !== 1'b1) begin bad++; $display("FAIL full_overflow: got %b want 1", evt_overflow); end
    for (int n = 0; n < 5; n++) begin
      pop_one(v, k, p, r);
      total++;
      if ({v, k, p, r} !== {1'b1, ek[n], ep[n], 1'b0}) begin
        bad++; $display("FAIL full_drain%0d: got v=%b key=%0d p=%b r=%b want v=1 key=%0d p=%b r=0",
                        n, v, k, p, r, ek[n], ep[n]);
      end
    end
    total++;
    if ({evt_valid, evt_overflow} !== 2'b01) begin
      bad++; $display("FAIL full_after: got v=%b ovf=%b want v=0 ovf=1", evt_valid, evt_overflow);
    end
  endtask

  task automatic test_repeat;
    logic ok;
    int at, n_ev;
    int ev_cyc [8];
    logic [KEY_IDX_W-1:0] ev_key [8];
    logic ev_p [8], ev_r [8];
`ifdef TM1638_KEY_AUTOREPEAT_EN
    int   exp_n = 5;
    int   exp_off [5] = '{1, 3001, 5001, 7001, 8001};
    logic exp_p [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic exp_r [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
`else
    int   exp_n = 2;
    int   exp_off [5] = '{1, 8001, 0, 0, 0};
    logic exp_p [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic exp_r [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
    do_reset(8'h00);
    evt_ready = 1'b1;
    keys[2] = 1'b1;
    wait_ks(8'h04, 3000, ok, at);
    n_ev = 0;
    for (int c = 0; c < 9500; c++) begin
      step();
      if (cyc == at + 6500) keys = 8'h00;
      if (evt_valid === 1'b1) begin
        if (n_ev < 8) begin
          ev_cyc[n_ev] = cyc;
          ev_key[n_ev] = evt_key;
          ev_p[n_ev] = evt_press;
          ev_r[n_ev] = evt_repeat;
        end
        n_ev++;
      end
    end
    evt_ready = 1'b0;
    total++;
    if (!ok || n_ev != exp_n) begin bad++; $display("FAIL repeat_count: got %0d events want %0d", n_ev, exp_n); end
    for (int n = 0; n < exp_n && n < n_ev; n++) begin
      total++;
      if (ev_key[n] !== 4'd2 || ev_p[n] !== exp_p[n] || ev_r[n] !== exp_r[n] || ev_cyc[n] != at + exp_off[n]) begin
        bad++; $display("FAIL repeat_ev%0d: got key=%0d p=%b r=%b cyc=%0d want key=2 p=%b r=%b cyc=%0d",
                        n, ev_key[n], ev_p[n], ev_r[n], ev_cyc[n], exp_p[n], exp_r[n], at + exp_off[n]);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic ok;
    int at;
    do_reset(8'h00);
    keys = 8'h07;
    wait_ks(8'h07, 3000, ok, at);
    step(5);
    total++;
    if ({evt_valid, evt_key} !== {1'b1, 4'd0}) begin
      bad++; $display("FAIL mid_prefill: got v=%b key=%0d want v=1 key=0", evt_valid, evt_key);
    end
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    total++;
    if ({evt_valid, key_state, evt_overflow} !== {1'b0, 8'h00, 1'b0}) begin
      bad++; $display("FAIL mid_async: got v=%b ks=%h ovf=%b want v=0 ks=00 ovf=0", evt_valid, key_state, evt_overflow);
    end
    step(2);
    rst_n = 1'b1;
    wait_ks(8'h07, 3000, ok, at);
    total++;
    if (!ok || at != 2000) begin bad++; $display("FAIL mid_repress: got cycle %0d want 2000", at); end
    step();
    total++;
    if ({evt_valid, evt_key, evt_press} !== {1'b1, 4'd0, 1'b1}) begin
      bad++; $display("FAIL mid_event: got v=%b key=%0d p=%b want v=1 key=0 p=1", evt_valid, evt_key, evt_press);
    end
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_simultaneous();
    test_full();
    test_repeat();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
